// File: rtl/estufa_planta_if.sv
// Command/sensor bundle between the greenhouse thermostat controller and the plant model.
interface estufa_planta_if;
  logic       aquecedor;
  logic       resfriador;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] temp;
  logic       t1;
  logic       t2;
  logic       erro;
  logic [1:0] estado;

  modport master (output aquecedor, resfriador, load, load_value,
                  input  temp, t1, t2, erro, estado);
  modport slave  (input  aquecedor, resfriador, load, load_value,
                  output temp, t1, t2, erro, estado);
endinterface

// File: rtl/estufa_planta.sv
// Greenhouse plant: integrates heater/cooler commands into a temperature register
// once per tick, drifts toward ambient when idle, and returns the two threshold bits.
module estufa_planta #(
  parameter int unsigned TEMP_INIT = 18,
  parameter int unsigned AMBIENT   = 18,
  parameter int unsigned TEMP_MAX  = 40,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned DRIFT_DIV = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  estufa_planta_if.slave   bus
);
  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int DW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DRIFT_LAST = DW'(DRIFT_DIV - 1);
  localparam logic [7:0]    TMAX       = 8'(TEMP_MAX);
  localparam logic [7:0]    AMB        = 8'(AMBIENT);
  localparam logic [7:0]    TINIT      = 8'(TEMP_INIT);

  typedef enum logic [1:0] {DRIFT = 2'd0, AQUECE = 2'd1, RESFRIA = 2'd2, FALHA = 2'd3} estado_t;

  logic [7:0]    temp_q,  temp_n;
  logic [TW-1:0] tick_q,  tick_n;
  logic [DW-1:0] drift_q, drift_n;
  logic          erro_q,  erro_n;
  estado_t       estado_q, estado_n;
  logic          tick;

  assign tick = (tick_q == TICK_LAST);

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      temp_q   <= TINIT;
      tick_q   <= '0;
      drift_q  <= '0;
      erro_q   <= 1'b0;
      estado_q <= DRIFT;
    end else begin
      temp_q   <= temp_n;
      tick_q   <= tick_n;
      drift_q  <= drift_n;
      erro_q   <= erro_n;
      estado_q <= estado_n;
    end
  end

  always_comb begin
    temp_n   = temp_q;
    tick_n   = tick_q;
    drift_n  = drift_q;
    erro_n   = erro_q;
    estado_n = estado_q;
    if (bus.load) begin
      // load restarts both dividers, so the next tick is a full period away
      temp_n   = (bus.load_value > TMAX) ? TMAX : bus.load_value;
      tick_n   = '0;
      drift_n  = '0;
      erro_n   = 1'b0;
      estado_n = DRIFT;
    end else begin
      tick_n = tick ? '0 : tick_q + 1'b1;
      if (tick) begin
        unique case ({bus.aquecedor, bus.resfriador})
          2'b10: begin
            estado_n = AQUECE;
            drift_n  = '0;
            if (temp_q < TMAX) temp_n = temp_q + 8'd1;
          end
          2'b01: begin
            estado_n = RESFRIA;
            drift_n  = '0;
            if (temp_q != 8'd0) temp_n = temp_q - 8'd1;
          end
          2'b11: begin
            estado_n = FALHA;
            drift_n  = '0;
            erro_n   = 1'b1;
          end
          default: begin
            estado_n = DRIFT;
            if (drift_q == DRIFT_LAST) begin
              drift_n = '0;
              if (temp_q < AMB)      temp_n = temp_q + 8'd1;
              else if (temp_q > AMB) temp_n = temp_q - 8'd1;
            end else begin
              drift_n = drift_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.temp   = temp_q;
  assign bus.t1     = (temp_q >= 8'd15);
  assign bus.t2     = (temp_q >= 8'd20);
  assign bus.erro   = erro_q;
  assign bus.estado = estado_q;
endmodule

// File: tb/tb_estufa_planta.sv
// Bench for estufa_planta: two instances (tick every cycle and every 3 cycles) driven
// identically, checked each cycle against an integer plant model plus literal expectations.
module tb_estufa_planta;
  localparam int TEMP_MAX  = 40;
  localparam int AMBIENT   = 18;
  localparam int TEMP_INIT = 18;
  localparam int DRIFT_DIV = 4;

  logic clk_2 = 1'b0;
  logic reset;
  estufa_planta_if b1();
  estufa_planta_if b3();

  estufa_planta #(.TEMP_INIT(TEMP_INIT), .AMBIENT(AMBIENT), .TEMP_MAX(TEMP_MAX),
                  .TICK_DIV(1), .DRIFT_DIV(DRIFT_DIV))
    dut1 (.clk_2(clk_2), .reset(reset), .bus(b1.slave));
  estufa_planta #(.TEMP_INIT(TEMP_INIT), .AMBIENT(AMBIENT), .TEMP_MAX(TEMP_MAX),
                  .TICK_DIV(3), .DRIFT_DIV(DRIFT_DIV))
    dut3 (.clk_2(clk_2), .reset(reset), .bus(b3.slave));

  always #5 clk_2 = ~clk_2;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // plant model: index 0 -> tick every cycle, index 1 -> tick every 3 cycles
  int tdiv[2] = '{1, 3};
  int m_temp[2], m_phase[2], m_idle[2], m_erro[2], m_est[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_temp[i] = TEMP_INIT; m_phase[i] = 0; m_idle[i] = 0; m_erro[i] = 0; m_est[i] = 0;
    end
  endtask

  task automatic model_edge(input bit aq, input bit rf, input bit ld, input int lv);
    for (int i = 0; i < 2; i++) begin
      if (ld) begin
        m_temp[i] = (lv > TEMP_MAX) ? TEMP_MAX : lv;
        m_phase[i] = 0; m_idle[i] = 0; m_erro[i] = 0; m_est[i] = 0;
      end else begin
        m_phase[i]++;
        if (m_phase[i] == tdiv[i]) begin
          m_phase[i] = 0;
          if (aq && rf) begin
            m_erro[i] = 1; m_est[i] = 3; m_idle[i] = 0;
          end else if (aq) begin
            m_temp[i] = (m_temp[i] + 1 > TEMP_MAX) ? TEMP_MAX : m_temp[i] + 1;
            m_est[i] = 1; m_idle[i] = 0;
          end else if (rf) begin
            m_temp[i] = (m_temp[i] - 1 < 0) ? 0 : m_temp[i] - 1;
            m_est[i] = 2; m_idle[i] = 0;
          end else begin
            m_est[i] = 0;
            m_idle[i]++;
            if (m_idle[i] == DRIFT_DIV) begin
              m_idle[i] = 0;
              if (m_temp[i] < AMBIENT) m_temp[i]++;
              else if (m_temp[i] > AMBIENT) m_temp[i]--;
            end
          end
        end
      end
    end
  endtask

  // drive one cycle's inputs, take the edge, advance the model, settle
  task automatic step(input bit aq, input bit rf, input bit ld, input int lv);
    b1.aquecedor = aq; b1.resfriador = rf; b1.load = ld; b1.load_value = 8'(lv);
    b3.aquecedor = aq; b3.resfriador = rf; b3.load = ld; b3.load_value = 8'(lv);
    @(posedge clk_2);
    model_edge(aq, rf, ld, lv);
    #1;
  endtask

  always @(negedge clk_2) begin
    if (chk_en) begin
      chk("temp1",   b1.temp,   m_temp[0]);
      chk("t1_1",    b1.t1,     m_temp[0] >= 15);
      chk("t2_1",    b1.t2,     m_temp[0] >= 20);
      chk("erro1",   b1.erro,   m_erro[0]);
      chk("estado1", b1.estado, m_est[0]);
      chk("temp3",   b3.temp,   m_temp[1]);
      chk("erro3",   b3.erro,   m_erro[1]);
      chk("estado3", b3.estado, m_est[1]);
    end
  end

  initial begin
    reset = 1'b1;
    b1.aquecedor = 0; b1.resfriador = 0; b1.load = 0; b1.load_value = 0;
    b3.aquecedor = 0; b3.resfriador = 0; b3.load = 0; b3.load_value = 0;
    model_reset();
    #12;
    chk("rst_temp", b1.temp, 18);
    chk("rst_t1", b1.t1, 1);
    chk("rst_t2", b1.t2, 0);
    chk("rst_erro", b1.erro, 0);
    chk("rst_estado", b1.estado, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // 1: idle at ambient
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0);
    chk("idle_temp", b1.temp, 18);

    // 2: heat and saturate
    step(1, 0, 0, 0);
    chk("heat1", b1.temp, 19);
    chk("heat1_t2", b1.t2, 0);
    step(1, 0, 0, 0);
    chk("heat2", b1.temp, 20);
    chk("heat2_t2", b1.t2, 1);
    for (int k = 0; k < 25; k++) step(1, 0, 0, 0);
    chk("sat_hi", b1.temp, 40);
    chk("sat_est", b1.estado, 1);

    // 3: load low, cool to floor, over-range load clamps
    step(0, 1, 1, 3);
    chk("load3", b1.temp, 3);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("cool0", b1.temp, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("sat_lo", b1.temp, 0);
    chk("sat_lo_t1", b1.t1, 0);
    chk("cool_est", b1.estado, 2);
    step(0, 0, 1, 200);
    chk("clamp", b1.temp, 40);

    // 4: conflict sets sticky erro, load clears it
    step(0, 0, 1, 20);
    step(1, 1, 0, 0);
    chk("fail_temp", b1.temp, 20);
    chk("fail_erro", b1.erro, 1);
    chk("fail_est", b1.estado, 3);
    step(1, 0, 0, 0);
    chk("post_temp", b1.temp, 21);
    chk("post_erro", b1.erro, 1);
    step(0, 0, 1, 21);
    chk("clr_erro", b1.erro, 0);

    // 5: drift down from 22, then up from 14
    step(0, 0, 1, 22);
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0, 0);
      if (k == 3)  chk("drift3", b1.temp, 22);
      if (k == 4)  chk("drift4", b1.temp, 21);
      if (k == 8)  chk("drift8", b1.temp, 20);
      if (k == 12) chk("drift12", b1.temp, 19);
      if (k == 16) chk("drift16", b1.temp, 18);
    end
    chk("drift20", b1.temp, 18);
    step(0, 0, 1, 14);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0);
      if (k == 3) chk("up_t1_lo", b1.t1, 0);
    end
    chk("up_temp", b1.temp, 15);
    chk("up_t1_hi", b1.t1, 1);

    // 6: async reset mid-heat, then slow-tick instance first step on 3rd edge
    step(0, 0, 1, 18);
    for (int k = 0; k < 7; k++) step(1, 0, 0, 0);
    chk("pre_rst", b1.temp, 25);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_temp", b1.temp, 18);
    chk("arst_est", b1.estado, 0);
    chk("arst_temp3", b3.temp, 18);
    #2;
    reset = 1'b0;
    step(1, 0, 0, 0);
    chk("slow_e1", b3.temp, 18);
    chk("slow_e1_est", b3.estado, 0);
    chk("fast_e1", b1.temp, 19);
    step(1, 0, 0, 0);
    chk("slow_e2", b3.temp, 18);
    step(1, 0, 0, 0);
    chk("slow_e3", b3.temp, 19);
    chk("slow_e3_est", b3.estado, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
